// File: rtl/cnn_stream_pkg.sv
// Shared types and constants for the streaming 3x3 convolution layer.
package cnn_stream_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StLoad  = 2'd1,
      StRun   = 2'd2,
      StFlush = 2'd3
   } state_e;

   localparam int KSIZE = 3;
   localparam int KTAPS = KSIZE * KSIZE;

   // Full-precision width of a 9-tap sum of pixel x coefficient products.
   function automatic int out_width(input int dw, input int fw);
      return dw + fw + 5;
   endfunction

endpackage

// File: rtl/cnn_stream_layer_if.sv
// Pixel-in / result-out stream handshakes of the convolution layer.
interface cnn_stream_layer_if #(
   parameter int DW = 4,
   parameter int FW = 4
);
   localparam int OW = cnn_stream_pkg::out_width(DW, FW);

   logic                 in_valid;
   logic                 in_ready;
   logic [DW-1:0]        in_data;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [OW-1:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface

// File: rtl/cnn_line_buffer.sv
// One image row of delay: a shift register that advances only on accepted pixels.
module cnn_line_buffer #(
   parameter int DEPTH = 6,
   parameter int DW    = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout
);

   logic [DW-1:0] mem_q [DEPTH];

   // Shift chain, oldest entry at the far end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (en) begin
         mem_q[0] <= din;
         for (int i = 1; i < DEPTH; i++) mem_q[i] <= mem_q[i-1];
      end
   end

   assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/cnn_stream_layer.sv
// Streaming 3x3 convolution over a raster-order image with a one-deep result register.
module cnn_stream_layer
   import cnn_stream_pkg::*;
#(
   parameter int DW        = 4,
   parameter int FW        = 4,
   parameter int IMG_W     = 6,
   parameter int IMG_H     = 6,
   parameter int IN_SIGNED = 0,
   parameter int RELU      = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 flt_load,
   input  logic signed [FW-1:0] flt_data,
   cnn_stream_layer_if.slave    bus,
   output logic                 busy,
   output logic                 frame_done
);

   localparam int OW = out_width(DW, FW);
   localparam int PW = DW + FW + 1;
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int KW = $clog2(KTAPS);

   state_e               state_q, state_d;
   logic [KW-1:0]        kidx_q;
   logic signed [FW-1:0] k_q [KTAPS];
   logic [CW-1:0]        col_q;
   logic [RW-1:0]        row_q;
   logic [DW-1:0]        win_q [KSIZE][KSIZE];
   logic [DW-1:0]        new_col [KSIZE];
   logic [DW-1:0]        tap [KTAPS];
   logic [DW-1:0]        lb0_out, lb1_out;
   logic signed [DW:0]   px;
   logic signed [PW-1:0] prod;
   logic signed [OW-1:0] sum, result;
   logic                 out_valid_q;
   logic signed [OW-1:0] out_data_q;
   logic                 accept, complete, last_px, k_we, clr_cnt;

   assign bus.in_ready = (state_q == StRun) && (!out_valid_q || bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;
   assign last_px      = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
   assign complete     = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Next state plus coefficient-write and counter-clear strobes.
   always_comb begin
      state_d = state_q;
      k_we    = 1'b0;
      clr_cnt = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
               clr_cnt = 1'b1;
            end else if (flt_load) begin
               state_d = StLoad;
               k_we    = 1'b1;
            end
         end
         StLoad: begin
            if (flt_load) begin
               k_we = 1'b1;
               if (kidx_q == KW'(KTAPS - 1)) state_d = StIdle;
            end
         end
         StRun: begin
            if (accept && last_px) state_d = StFlush;
         end
         StFlush: begin
            if (out_valid_q && bus.out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Coefficient store; kidx is 0 whenever the FSM sits in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kidx_q <= '0;
         for (int i = 0; i < KTAPS; i++) k_q[i] <= '0;
      end else if (k_we) begin
         k_q[kidx_q] <= flt_data;
         kidx_q      <= (kidx_q == KW'(KTAPS - 1)) ? '0 : kidx_q + KW'(1);
      end
   end

   // Raster position of the next pixel to be accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q <= '0;
         row_q <= '0;
      end else if (clr_cnt) begin
         col_q <= '0;
         row_q <= '0;
      end else if (accept) begin
         if (col_q == CW'(IMG_W - 1)) begin
            col_q <= '0;
            row_q <= (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
         end else begin
            col_q <= col_q + CW'(1);
         end
      end
   end

   cnn_line_buffer #(.DEPTH(IMG_W), .DW(DW)) u_lb0 (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (accept),
      .din  (bus.in_data),
      .dout (lb0_out)
   );

   cnn_line_buffer #(.DEPTH(IMG_W), .DW(DW)) u_lb1 (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (accept),
      .din  (lb0_out),
      .dout (lb1_out)
   );

   assign new_col[0] = lb1_out;
   assign new_col[1] = lb0_out;
   assign new_col[2] = bus.in_data;

   // Window as it will look once the incoming pixel is shifted in; feeds both MAC and window.
   always_comb begin
      for (int r = 0; r < KSIZE; r++) begin
         for (int c = 0; c < KSIZE; c++) begin
            tap[r*KSIZE+c] = (c < KSIZE - 1) ? win_q[r][c+1] : new_col[r];
         end
      end
   end

   // 3x3 window register, top row oldest.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < KSIZE; r++)
            for (int c = 0; c < KSIZE; c++) win_q[r][c] <= '0;
      end else if (accept) begin
         for (int r = 0; r < KSIZE; r++)
            for (int c = 0; c < KSIZE; c++) win_q[r][c] <= tap[r*KSIZE+c];
      end
   end

   // Full-precision multiply-accumulate with optional ReLU clamp.
   always_comb begin
      sum  = '0;
      px   = '0;
      prod = '0;
      for (int i = 0; i < KTAPS; i++) begin
         px   = (IN_SIGNED != 0) ? {tap[i][DW-1], tap[i]} : {1'b0, tap[i]};
         prod = PW'(k_q[i]) * PW'(px);
         sum  = sum + OW'(prod);
      end
      result = ((RELU != 0) && sum[OW-1]) ? '0 : sum;
   end

   // Result register; a new result may replace one being consumed in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else if (complete) begin
         out_valid_q <= 1'b1;
         out_data_q  <= result;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign busy          = (state_q != StIdle);
   assign frame_done    = (state_q == StFlush) && out_valid_q && bus.out_ready;

endmodule

// File: tb/tb_cnn_stream_layer.sv
// Directed + randomized bench for cnn_stream_layer; two instances (RELU off / on) share stimulus.
module tb_cnn_stream_layer;
   import cnn_stream_pkg::*;

   localparam int DW   = 4;
   localparam int FW   = 4;
   localparam int IW   = 6;
   localparam int IH   = 6;
   localparam int NPIX = IW * IH;
   localparam int NRES = (IW - 2) * (IH - 2);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          flt_load = 1'b0;
   logic [FW-1:0] flt_data = '0;
   logic          busy0, busy1, fd0, fd1;

   int tests = 0;
   int fails = 0;
   int kc [KTAPS];
   int img [IH][IW];

   cnn_stream_layer_if #(.DW(DW), .FW(FW)) bus0 ();
   cnn_stream_layer_if #(.DW(DW), .FW(FW)) bus1 ();

   assign bus1.in_valid  = bus0.in_valid;
   assign bus1.in_data   = bus0.in_data;
   assign bus1.out_ready = bus0.out_ready;

   cnn_stream_layer #(.DW(DW), .FW(FW), .IMG_W(IW), .IMG_H(IH), .IN_SIGNED(0), .RELU(0)) dut0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .flt_load  (flt_load),
      .flt_data  (flt_data),
      .bus       (bus0),
      .busy      (busy0),
      .frame_done(fd0)
   );

   cnn_stream_layer #(.DW(DW), .FW(FW), .IMG_W(IW), .IMG_H(IH), .IN_SIGNED(0), .RELU(1)) dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .flt_load  (flt_load),
      .flt_data  (flt_data),
      .bus       (bus1),
      .busy      (busy1),
      .frame_done(fd1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: 3x3 dot product ending at bottom-right pixel (r,c).
   function automatic int conv(input int r, input int c, input bit relu);
      int s = 0;
      for (int i = 0; i < KTAPS; i++) s += kc[i] * img[r-2+i/3][c-2+i%3];
      if (relu && s < 0) s = 0;
      return s;
   endfunction

   task automatic check_zero(input string tag);
      chk({tag, "_out_valid"}, bus0.out_valid, 0);
      chk({tag, "_out_valid1"}, bus1.out_valid, 0);
      chk({tag, "_in_ready"}, bus0.in_ready, 0);
      chk({tag, "_in_ready1"}, bus1.in_ready, 0);
      chk({tag, "_busy"}, busy0, 0);
      chk({tag, "_busy1"}, busy1, 0);
      chk({tag, "_frame_done"}, fd0, 0);
      chk({tag, "_frame_done1"}, fd1, 0);
      chk({tag, "_out_data"}, bus0.out_data, 0);
      chk({tag, "_out_data1"}, bus1.out_data, 0);
   endtask

   task automatic load_coeffs();
      for (int i = 0; i < KTAPS; i++) begin
         @(negedge clk);
         flt_load = 1'b1;
         flt_data = FW'(kc[i]);
         if (i > 0) chk("busy_load", busy0, 1);
         if (i < KTAPS - 1) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
               @(negedge clk);
               flt_load = 1'b0;
               flt_data = FW'($urandom);
               #1;
               chk("busy_load_gap", busy0, 1);
               chk("in_ready_load", bus0.in_ready, 0);
            end
         end
      end
      @(negedge clk);
      flt_load = 1'b0;
      #1;
      chk("idle_after_load", busy0, 0);
   endtask

   // rmode: 0 always ready, 1 random ready, 2 stall 5 cycles at the first result.
   task automatic run_frame(input bit rnd_valid, input int rmode, input bit inject,
                            input int abort_at, input bit with_load);
      int acc = 0, prod = 0, cons = 0, stall = 0;
      bit ev, rdy, rr, done = 0, prev_stall = 0;
      logic signed [31:0] prev0 = 0, prev1 = 0;
      int e0[$], e1[$];
      for (int r = 2; r < IH; r++)
         for (int c = 2; c < IW; c++) begin
            e0.push_back(conv(r, c, 0));
            e1.push_back(conv(r, c, 1));
         end
      @(negedge clk);
      start = 1'b1;
      flt_load = with_load;
      flt_data = FW'($urandom);
      bus0.in_valid = 1'b0;
      bus0.out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      flt_load = 1'b0;
      chk("busy_run", busy0, 1);
      for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
         if (cyc > 0) @(negedge clk);
         ev = prod > cons;
         case (rmode)
            0: rr = 1'b1;
            1: rr = ($urandom_range(0, 3) != 0);
            default: begin
               if (ev && stall < 5) begin
                  rr = 1'b0;
                  stall++;
               end else rr = 1'b1;
            end
         endcase
         bus0.out_ready = rr;
         if (acc < NPIX) begin
            bus0.in_valid = rnd_valid ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus0.in_data  = DW'(img[acc/IW][acc%IW]);
         end else begin
            bus0.in_valid = 1'b0;
         end
         if (inject && acc < NPIX && cyc % 5 == 2) begin
            start = 1'b1;
            flt_load = 1'b1;
            flt_data = FW'($urandom);
         end else begin
            start = 1'b0;
            flt_load = 1'b0;
         end
         #1;
         rdy = (acc < NPIX) && (!ev || rr);
         chk("out_valid", bus0.out_valid, ev);
         chk("out_valid_relu", bus1.out_valid, ev);
         chk("in_ready", bus0.in_ready, rdy);
         chk("frame_done", fd0, (acc == NPIX) && ev && rr && (cons == NRES - 1));
         chk("frame_done_relu", fd1, (acc == NPIX) && ev && rr && (cons == NRES - 1));
         if (prev_stall) begin
            chk("hold_data", bus0.out_data, prev0);
            chk("hold_data_relu", bus1.out_data, prev1);
         end
         if (ev && rr) begin
            chk("result", bus0.out_data, e0[cons]);
            chk("result_relu", bus1.out_data, e1[cons]);
            cons++;
            if (cons == NRES) done = 1'b1;
         end
         if (bus0.in_valid && rdy) begin
            if (acc / IW >= 2 && acc % IW >= 2) prod++;
            acc++;
         end
         prev_stall = ev && !rr;
         prev0 = bus0.out_data;
         prev1 = bus1.out_data;
         if (abort_at > 0 && acc == abort_at) break;
      end
      if (abort_at == 0) begin
         chk("frame_complete", cons, NRES);
         @(negedge clk);
         start = 1'b0;
         flt_load = 1'b0;
         bus0.in_valid = 1'b0;
         #1;
         chk("idle_after_frame", busy0, 0);
         chk("idle_after_frame_relu", busy1, 0);
      end
   endtask

   initial begin
      bus0.in_valid  = 1'b0;
      bus0.in_data   = '0;
      bus0.out_ready = 1'b0;
      #1;
      check_zero("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // All-ones filter on all-ones image: every result 9.
      for (int i = 0; i < KTAPS; i++) kc[i] = 1;
      for (int r = 0; r < IH; r++) for (int c = 0; c < IW; c++) img[r][c] = 1;
      load_coeffs();
      run_frame(0, 0, 0, 0, 0);

      // Centre-tap identity filter on a ramp image.
      for (int i = 0; i < KTAPS; i++) kc[i] = (i == 4) ? 1 : 0;
      for (int r = 0; r < IH; r++) for (int c = 0; c < IW; c++) img[r][c] = (6 * r + c) % 16;
      chk("ramp_first_ref", conv(2, 2, 0), 7);
      load_coeffs();
      run_frame(0, 0, 0, 0, 0);

      // Same frame, coefficients retained, consumer stalls 5 cycles at the first result.
      run_frame(0, 2, 0, 0, 0);

      // Most negative filter on saturated image: -1080, clamped to 0 with ReLU.
      for (int i = 0; i < KTAPS; i++) kc[i] = -8;
      for (int r = 0; r < IH; r++) for (int c = 0; c < IW; c++) img[r][c] = 15;
      load_coeffs();
      run_frame(1, 1, 0, 0, 1);

      // Random filter/image with start and flt_load pulsed during RUN.
      for (int i = 0; i < KTAPS; i++) kc[i] = int'($urandom_range(0, 15)) - 8;
      for (int r = 0; r < IH; r++) for (int c = 0; c < IW; c++) img[r][c] = $urandom_range(0, 15);
      load_coeffs();
      run_frame(1, 1, 1, 0, 0);
      for (int r = 0; r < IH; r++) for (int c = 0; c < IW; c++) img[r][c] = $urandom_range(0, 15);
      run_frame(1, 1, 0, 0, 0);

      // Asynchronous reset mid-frame after 20 pixels.
      run_frame(1, 1, 0, 20, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("midframe_reset");
      @(negedge clk);
      bus0.in_valid = 1'b0;
      rst_n = 1'b1;
      // Coefficients were cleared: a frame without reload yields all zeros.
      for (int i = 0; i < KTAPS; i++) kc[i] = 0;
      run_frame(0, 0, 0, 0, 0);
      for (int i = 0; i < KTAPS; i++) kc[i] = int'($urandom_range(0, 15)) - 8;
      for (int r = 0; r < IH; r++) for (int c = 0; c < IW; c++) img[r][c] = $urandom_range(0, 15);
      load_coeffs();
      run_frame(1, 1, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cnn_stream_layer.md
CNN_STREAM_LAYER -- requirements
Module: cnn_stream_layer

Interface
REQ-001 SHALL have parameter DW, 4, input pixel width.
REQ-002 SHALL have parameter FW, 4, signed filter coefficient width.
REQ-003 SHALL have parameter IMG_W, 6, image columns (>=3).
REQ-004 SHALL have parameter IMG_H, 6, image rows (>=3).
REQ-005 SHALL have parameter IN_SIGNED, 0, 1 = pixels two's complement, 0 = unsigned.
REQ-006 SHALL have parameter RELU, 0, 1 = clamp negative results to 0.
REQ-007 SHALL have derived constant OW = DW+FW+5, output width.
REQ-008 SHALL have port clk  in  1  single clock, rising edge.
REQ-009 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-010 SHALL have port start  in  1  begin frame (IDLE only).
REQ-011 SHALL have port flt_load  in  1  coefficient write strobe.
REQ-012 SHALL have port flt_data  in  FW  signed coefficient, raster order k0..k8.
REQ-013 SHALL have port in_valid / in_ready  in / out  1  pixel handshake.
REQ-014 SHALL have port in_data  in  DW  pixel, raster order.
REQ-015 SHALL have port out_valid / out_ready  out / in  1  result handshake.
REQ-016 SHALL have port out_data  out  OW  signed convolution result.
REQ-017 SHALL have port busy  out  1  high in any state but IDLE.
REQ-018 SHALL have port frame_done  out  1  one-cycle pulse at frame end.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, RUN, FLUSH.
REQ-020 SHALL leave IDLE for LOAD on flt_load and store flt_data as k0 in that cycle.
REQ-021 SHALL, in LOAD, store one coefficient per cycle with flt_load high; gaps allowed; return to IDLE after k8.
REQ-022 SHALL give start priority over flt_load when both are high in IDLE; flt_load is ignored.
REQ-023 SHALL ignore start and flt_load in LOAD, RUN and FLUSH.
REQ-024 SHALL, on start in IDLE, clear row/column counters and enter RUN; coefficients are retained across frames.
REQ-025 SHALL drive in_ready = (state==RUN) && (!out_valid || out_ready).
REQ-026 SHALL count a pixel as accepted only when in_valid && in_ready.
REQ-027 SHALL feed two IMG_W-deep line buffers and a 3x3 window from accepted pixels.
REQ-028 SHALL produce one result per accepted pixel at row>=2, col>=2: (IMG_W-2)*(IMG_H-2) results per frame.
REQ-029 SHALL compute result = sum over i of k_i*w_i in full precision (w0 = top-left, raster order); sign-extend pixels when IN_SIGNED, else zero-extend; no overflow possible at OW.
REQ-030 SHALL, when RELU=1, output 0 for negative sums.
REQ-031 SHALL register the result: out_valid rises the cycle after the completing pixel is accepted.
REQ-032 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-033 SHALL, when a result is consumed and a new one completes in the same cycle, load the new result with out_valid staying high.
REQ-034 SHALL move RUN->FLUSH after the IMG_W*IMG_H-th pixel is accepted.
REQ-035 SHALL move FLUSH->IDLE when the last result is consumed, and pulse frame_done in that cycle.

Reset
REQ-036 SHALL, on rst_n low (asynchronous, including mid-frame), set state IDLE, all counters, line buffers, window and coefficients to 0, and out_valid, in_ready, busy, frame_done and out_data to 0.

Structure
REQ-037 SHALL place the state enum, KSIZE=3, KTAPS=9 and an OW-width function in the shared package cnn_stream_pkg.
REQ-038 SHALL instantiate the sub-module cnn_line_buffer (IMG_W deep, DW wide, shift-enable) twice.

Verification
REQ-039 SHALL cover: all coefficients 1, 6x6 image all 1 -> 16 results of 9, then one frame_done.
REQ-040 SHALL cover: k4=1, others 0, pixel(r,c)=(6r+c) mod 16 -> first result 7, results follow the centre pixels in raster order.
REQ-041 SHALL cover: all coefficients -8, image all 15 -> each result -1080; with RELU=1 -> each 0.
REQ-042 SHALL cover: out_ready low 5 cycles at the first result -> out_data held, in_ready low, sequence from REQ-040 unchanged and complete.
REQ-043 SHALL cover: rst_n low after 20 pixels -> all outputs 0 and coefficients 0; reload and restart -> correct full frame.
REQ-044 SHALL cover: start and flt_load pulsed during RUN -> ignored, coefficients and result stream unchanged.
